// File: rtl/cpu_pkg.sv
// Shared types and opcode map for the 16-bit CPU control path.
package cpu_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        EXECUTE  = 3'd2,
        MEM_WAIT = 3'd3,
        HALT     = 3'd4
    } state_t;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ALU   = 4'h1;
    localparam logic [3:0] OP_ALUI  = 4'h2;
    localparam logic [3:0] OP_LDI   = 4'h3;
    localparam logic [3:0] OP_LOAD  = 4'h4;
    localparam logic [3:0] OP_STORE = 4'h5;
    localparam logic [3:0] OP_JMP   = 4'h6;
    localparam logic [3:0] OP_HALT  = 4'h7;
    localparam logic [3:0] OP_JZ    = 4'h8;
    localparam logic [3:0] OP_JNZ   = 4'h9;

    // Counter must hold 0..lat; a zero-latency memory still needs a 1-bit counter.
    function automatic int wait_width(input int lat);
        return (lat > 0) ? $clog2(lat + 1) : 1;
    endfunction

endpackage

// File: rtl/instr_decode.sv
// Opcode + zero flag to per-instruction datapath strobes, ungated by FSM state.
module instr_decode
    import cpu_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic       z_out,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       mem_write,
    output logic       alu_override_imm4,
    output logic       alu_override_imm8,
    output logic       alu_set_flags,
    output logic       set_pc,
    output logic       pc_from_register,
    output logic       is_load,
    output logic       is_halt,
    output logic       illegal_op
);

    always_comb begin
        reg_write         = 1'b0;
        mem_to_reg        = 1'b0;
        mem_write         = 1'b0;
        alu_override_imm4 = 1'b0;
        alu_override_imm8 = 1'b0;
        alu_set_flags     = 1'b0;
        set_pc            = 1'b0;
        pc_from_register  = 1'b0;
        is_load           = 1'b0;
        is_halt           = 1'b0;
        illegal_op        = 1'b0;
        case (opcode)
            OP_NOP: ;
            OP_ALU: begin
                reg_write     = 1'b1;
                alu_set_flags = 1'b1;
            end
            OP_ALUI: begin
                reg_write         = 1'b1;
                alu_set_flags     = 1'b1;
                alu_override_imm4 = 1'b1;
            end
            OP_LDI: begin
                reg_write         = 1'b1;
                alu_override_imm8 = 1'b1;
            end
            OP_LOAD: begin
                // The register write itself is timed by the FSM against memory latency.
                mem_to_reg = 1'b1;
                is_load    = 1'b1;
            end
            OP_STORE: mem_write = 1'b1;
            OP_JMP: begin
                set_pc           = 1'b1;
                pc_from_register = 1'b1;
            end
            OP_HALT: is_halt = 1'b1;
            OP_JZ: begin
                set_pc           = z_out;
                pc_from_register = z_out;
            end
            OP_JNZ: begin
                set_pc           = ~z_out;
                pc_from_register = ~z_out;
            end
            default: illegal_op = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle instruction sequencer: fetch / execute / memory wait with run, single-step and sticky halt.
module control_fsm
    import cpu_pkg::*;
#(
    parameter int MEM_LATENCY = 1
)
(
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic        step,
    input  logic [15:0] current_instruction,
    input  logic        Z_out,
    output logic        fetch_instruction,
    output logic        set_pc,
    output logic        pc_from_register,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        mem_write,
    output logic        alu_override_imm4,
    output logic        alu_override_imm8,
    output logic        alu_set_flags,
    output logic        halted,
    output logic        illegal_op,
    output logic [2:0]  state_poke
);

    localparam int WCW = wait_width(MEM_LATENCY);
    localparam logic [WCW-1:0] FETCH_LAST = WCW'(MEM_LATENCY);
    localparam logic [WCW-1:0] WAIT_LAST  = WCW'((MEM_LATENCY > 0) ? MEM_LATENCY - 1 : 0);

    state_t         state, state_nxt;
    logic [WCW-1:0] wait_cnt, wait_nxt;
    logic           one_shot, one_shot_nxt;

    logic d_reg_write, d_mem_to_reg, d_mem_write, d_imm4, d_imm8, d_set_flags;
    logic d_set_pc, d_pc_from_reg, d_is_load, d_is_halt, d_illegal;

    // Operand fields are consumed by the datapath, not by sequencing.
    logic unused_operands;
    assign unused_operands = ^current_instruction[11:0];

    instr_decode u_decode (
        .opcode            (current_instruction[15:12]),
        .z_out             (Z_out),
        .reg_write         (d_reg_write),
        .mem_to_reg        (d_mem_to_reg),
        .mem_write         (d_mem_write),
        .alu_override_imm4 (d_imm4),
        .alu_override_imm8 (d_imm8),
        .alu_set_flags     (d_set_flags),
        .set_pc            (d_set_pc),
        .pc_from_register  (d_pc_from_reg),
        .is_load           (d_is_load),
        .is_halt           (d_is_halt),
        .illegal_op        (d_illegal)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
            one_shot <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            one_shot <= one_shot_nxt;
        end
    end

    always_comb begin
        state_nxt         = state;
        wait_nxt          = wait_cnt;
        one_shot_nxt      = one_shot;
        fetch_instruction = 1'b0;
        set_pc            = 1'b0;
        pc_from_register  = 1'b0;
        reg_write         = 1'b0;
        mem_to_reg        = 1'b0;
        mem_write         = 1'b0;
        alu_override_imm4 = 1'b0;
        alu_override_imm8 = 1'b0;
        alu_set_flags     = 1'b0;
        halted            = 1'b0;
        illegal_op        = 1'b0;

        case (state)
            IDLE: begin
                if (run) begin
                    state_nxt = FETCH;
                end else if (step) begin
                    state_nxt    = FETCH;
                    one_shot_nxt = 1'b1;
                end
            end
            FETCH: begin
                fetch_instruction = 1'b1;
                if (wait_cnt == FETCH_LAST) begin
                    set_pc    = 1'b1;
                    state_nxt = EXECUTE;
                end else begin
                    wait_nxt = wait_cnt + WCW'(1);
                end
            end
            EXECUTE: begin
                reg_write         = d_reg_write;
                mem_to_reg        = d_mem_to_reg;
                mem_write         = d_mem_write;
                alu_override_imm4 = d_imm4;
                alu_override_imm8 = d_imm8;
                alu_set_flags     = d_set_flags;
                set_pc            = d_set_pc;
                pc_from_register  = d_pc_from_reg;
                illegal_op        = d_illegal;
                if (d_is_halt) begin
                    state_nxt = HALT;
                end else if (d_is_load && MEM_LATENCY > 0) begin
                    state_nxt = MEM_WAIT;
                end else begin
                    if (d_is_load) reg_write = 1'b1;
                    state_nxt    = (run && !one_shot) ? FETCH : IDLE;
                    one_shot_nxt = 1'b0;
                end
            end
            MEM_WAIT: begin
                mem_to_reg = 1'b1;
                if (wait_cnt == WAIT_LAST) begin
                    reg_write    = 1'b1;
                    state_nxt    = (run && !one_shot) ? FETCH : IDLE;
                    one_shot_nxt = 1'b0;
                end else begin
                    wait_nxt = wait_cnt + WCW'(1);
                end
            end
            HALT: halted = 1'b1;
            default: state_nxt = IDLE;
        endcase

        if (state_nxt != state) wait_nxt = '0;
    end

    assign state_poke = state;

endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm: directed vector table, hand sequences, randomized run against a cycle-list model.
module tb_control_fsm;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic [15:0] current_instruction = 16'h0000;
    logic        Z_out = 1'b0;
    logic [13:0] act1, act0;

    int tests = 0;
    int failures = 0;

    always #5 clock = ~clock;

    // {fetch,set_pc,pc_from_reg,reg_write,mem_to_reg,mem_write,imm4,imm8,set_flags,halted,illegal,state[2:0]}
    localparam logic [13:0] B_F  = 14'h2000, B_SP = 14'h1000, B_PR = 14'h0800, B_RW = 14'h0400;
    localparam logic [13:0] B_MR = 14'h0200, B_MW = 14'h0100, B_I4 = 14'h0080, B_I8 = 14'h0040;
    localparam logic [13:0] B_SF = 14'h0020, B_H  = 14'h0010, B_IL = 14'h0008;
    localparam logic [13:0] FE = B_F | 14'd1, FL = B_F | B_SP | 14'd1;

    control_fsm #(.MEM_LATENCY(1)) dut1 (
        .clock(clock), .reset(reset), .run(run), .step(step),
        .current_instruction(current_instruction), .Z_out(Z_out),
        .fetch_instruction(act1[13]), .set_pc(act1[12]), .pc_from_register(act1[11]),
        .reg_write(act1[10]), .mem_to_reg(act1[9]), .mem_write(act1[8]),
        .alu_override_imm4(act1[7]), .alu_override_imm8(act1[6]), .alu_set_flags(act1[5]),
        .halted(act1[4]), .illegal_op(act1[3]), .state_poke(act1[2:0])
    );

    control_fsm #(.MEM_LATENCY(0)) dut0 (
        .clock(clock), .reset(reset), .run(run), .step(step),
        .current_instruction(current_instruction), .Z_out(Z_out),
        .fetch_instruction(act0[13]), .set_pc(act0[12]), .pc_from_register(act0[11]),
        .reg_write(act0[10]), .mem_to_reg(act0[9]), .mem_write(act0[8]),
        .alu_override_imm4(act0[7]), .alu_override_imm8(act0[6]), .alu_set_flags(act0[5]),
        .halted(act0[4]), .illegal_op(act0[3]), .state_poke(act0[2:0])
    );

    typedef struct {
        logic        run;
        logic        step;
        logic [15:0] instr;
        logic        z;
        logic [13:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic ru, st, input logic [15:0] ins, input logic zz, input logic [13:0] e);
        vec_t v;
        v.run = ru; v.step = st; v.instr = ins; v.z = zz; v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic r, ru, st, input logic [15:0] ins, input logic zz);
        @(posedge clock);
        #1;
        reset = r; run = ru; step = st; current_instruction = ins; Z_out = zz;
        @(negedge clock);
    endtask

    // Model: each started instruction expands into a list of cycle kinds.
    localparam int K_FE = 1, K_FL = 2, K_EX = 3, K_MW = 4, K_ML = 5;
    int mq[2][$];
    bit m_halt[2];
    bit m_os[2];

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 0;
    endfunction

    function automatic logic [13:0] exp_out(input int kind, input logic [15:0] ins, input logic zz, input int lat);
        logic [13:0] e;
        case (kind)
            K_FE: e = FE;
            K_FL: e = FL;
            K_MW: e = B_MR | 14'd3;
            K_ML: e = B_MR | B_RW | 14'd3;
            default: begin
                e = 14'd2;
                case (ins[15:12])
                    4'h0, 4'h7: ;
                    4'h1: e = e | B_RW | B_SF;
                    4'h2: e = e | B_RW | B_SF | B_I4;
                    4'h3: e = e | B_RW | B_I8;
                    4'h4: e = e | B_MR | ((lat == 0) ? B_RW : 14'h0);
                    4'h5: e = e | B_MW;
                    4'h6: e = e | B_SP | B_PR;
                    4'h8: if (zz)  e = e | B_SP | B_PR;
                    4'h9: if (!zz) e = e | B_SP | B_PR;
                    default: e = e | B_IL;
                endcase
            end
        endcase
        return e;
    endfunction

    task automatic push_fetch(input int i);
        for (int k = 0; k < lat_of(i); k++) mq[i].push_back(K_FE);
        mq[i].push_back(K_FL);
    endtask

    function automatic logic [13:0] model_out(input int i);
        if (!reset) return '0;
        if (m_halt[i]) return B_H | 14'd4;
        if (mq[i].size() == 0) return '0;
        return exp_out(mq[i][0], current_instruction, Z_out, lat_of(i));
    endfunction

    task automatic model_edge(input int i);
        int kind;
        if (!reset) begin
            mq[i].delete(); m_halt[i] = 0; m_os[i] = 0;
            return;
        end
        if (m_halt[i]) return;
        if (mq[i].size() == 0) begin
            if (run) begin push_fetch(i); m_os[i] = 0; end
            else if (step) begin push_fetch(i); m_os[i] = 1; end
            return;
        end
        kind = mq[i].pop_front();
        if (kind == K_EX) begin
            if (current_instruction[15:12] == 4'h7) begin
                m_halt[i] = 1;
                return;
            end
            if (current_instruction[15:12] == 4'h4 && lat_of(i) > 0) begin
                for (int k = 0; k < lat_of(i) - 1; k++) mq[i].push_back(K_MW);
                mq[i].push_back(K_ML);
            end
        end
        if (kind == K_FL) mq[i].push_back(K_EX);
        if (mq[i].size() == 0) begin
            if (run && !m_os[i]) push_fetch(i);
            m_os[i] = 0;
        end
    endtask

    initial begin
        logic [3:0] op;

        // LDI free-run, then run dropped
        add(1,0,16'h3A05,0,14'h0); add(1,0,16'h3A05,0,FE); add(1,0,16'h3A05,0,FL);
        add(1,0,16'h3A05,0,B_RW|B_I8|14'd2); add(0,0,16'h3A05,0,FE); add(0,0,16'h3A05,0,FL);
        add(0,0,16'h3A05,0,B_RW|B_I8|14'd2); add(0,0,16'h3A05,0,14'h0);
        // LOAD with one wait cycle
        add(1,0,16'h4120,0,14'h0); add(0,0,16'h4120,0,FE); add(0,0,16'h4120,0,FL);
        add(0,0,16'h4120,0,B_MR|14'd2); add(0,0,16'h4120,0,B_MR|B_RW|14'd3); add(0,0,16'h4120,0,14'h0);
        // JZ single-step, Z=0 then Z=1; step in FETCH and run at one-shot end ignored
        add(0,1,16'h8300,0,14'h0); add(0,1,16'h8300,0,FE); add(0,0,16'h8300,0,FL);
        add(0,0,16'h8300,0,14'd2); add(0,1,16'h8300,1,14'h0); add(0,0,16'h8300,1,FE);
        add(0,0,16'h8300,1,FL); add(1,0,16'h8300,1,B_SP|B_PR|14'd2); add(0,0,16'h8300,1,14'h0);
        // illegal opcode
        add(0,1,16'hF000,0,14'h0); add(0,0,16'hF000,0,FE); add(0,0,16'hF000,0,FL);
        add(0,0,16'hF000,0,B_IL|14'd2); add(0,0,16'hF000,0,14'h0);
        // JNZ taken, STORE, ALU
        add(0,1,16'h9300,0,14'h0); add(0,0,16'h9300,0,FE); add(0,0,16'h9300,0,FL);
        add(0,0,16'h9300,0,B_SP|B_PR|14'd2); add(0,0,16'h9300,0,14'h0);
        add(0,1,16'h5120,0,14'h0); add(0,0,16'h5120,0,FE); add(0,0,16'h5120,0,FL);
        add(0,0,16'h5120,0,B_MW|14'd2); add(0,0,16'h5120,0,14'h0);
        add(0,1,16'h1234,0,14'h0); add(0,0,16'h1234,0,FE); add(0,0,16'h1234,0,FL);
        add(0,0,16'h1234,0,B_RW|B_SF|14'd2); add(0,0,16'h1234,0,14'h0);

        @(negedge clock);
        check("reset_lat1", act1, 14'h0);
        check("reset_lat0", act0, 14'h0);

        foreach (tbl[n]) begin
            cyc(1, tbl[n].run, tbl[n].step, tbl[n].instr, tbl[n].z);
            check($sformatf("vec%0d", n), act1, tbl[n].exp);
        end

        // Zero-latency LOAD writes in EXECUTE
        cyc(0,0,0,16'h4120,0);
        cyc(1,1,0,16'h4120,0); check("lat0_load_idle", act0, 14'h0);
        cyc(1,0,0,16'h4120,0); check("lat0_load_fetch", act0, FL);
        cyc(1,0,0,16'h4120,0); check("lat0_load_exec", act0, B_MR|B_RW|14'd2);
        cyc(1,0,0,16'h4120,0); check("lat0_load_idle2", act0, 14'h0);

        // HALT sticky, then async reset clears it and aborts a fetch
        cyc(0,0,0,16'h7000,0);
        cyc(1,1,0,16'h7000,0); check("halt_idle", act1, 14'h0);
        cyc(1,1,0,16'h7000,0); check("halt_fetch0", act1, FE);
        cyc(1,1,0,16'h7000,0); check("halt_fetch1", act1, FL);
        cyc(1,1,0,16'h7000,0); check("halt_exec", act1, 14'd2);
        for (int k = 0; k < 20; k++) begin
            cyc(1, 1'($urandom_range(0,1)), 1'($urandom_range(0,1)), 16'h0000, 0);
            check("halt_sticky", act1, B_H|14'd4);
        end
        cyc(0,1,0,16'h0000,0); check("halt_reset", act1, 14'h0);
        cyc(1,1,0,16'h0000,0); check("rst_fetch_idle", act1, 14'h0);
        cyc(1,1,0,16'h0000,0); check("rst_fetch_f0", act1, FE);
        cyc(0,1,0,16'h0000,0); check("rst_mid_fetch", act1, 14'h0);
        cyc(1,0,0,16'h0000,0); check("rst_mid_fetch_idle", act1, 14'h0);

        // Randomized run, both latencies against the model
        for (int c = 0; c < 3000; c++) begin
            @(posedge clock);
            #1;
            reset = (c == 0) ? 1'b0 : ($urandom_range(0,59) != 0);
            run   = ($urandom_range(0,3) != 0);
            step  = ($urandom_range(0,2) == 0);
            op    = 4'($urandom_range(0,15));
            if (op == 4'h7 && $urandom_range(0,7) != 0) op = 4'h0;
            current_instruction = {op, 12'($urandom)};
            Z_out = 1'($urandom_range(0,1));
            @(negedge clock);
            check("rand_lat1", act1, model_out(0));
            check("rand_lat0", act0, model_out(1));
            model_edge(0);
            model_edge(1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
